// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : 8-digit multiplexed seven-segment scan controller. It holds a
//            double-buffered ASCII display and inserts a guard gap per slot.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int SCAN_DIV = 100000,
  parameter int GAP      = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_char,
  input  logic       shift_en,
  input  logic [7:0] shift_char,
  input  logic       commit,
  input  logic       blank,
  output logic [7:0] char_out,
  output logic [7:0] dig_n,
  output logic       frame_tick,
  output logic       commit_pending
);

  localparam int               CNT_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] C_DIV_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [7:0]       C_SPACE   = 8'h20;

  logic [CNT_W-1:0] r_div_cnt;
  logic [2:0]       r_digit_idx;
  logic [7:0]       r_shadow  [8];
  logic [7:0]       r_display [8];
  logic [7:0]       w_shadow_nxt [8];
  logic             w_slot_end;
  logic             w_boundary;
  logic             w_gap_phase;
  logic             w_copy;

  assign w_slot_end = (r_div_cnt == C_DIV_MAX);
  assign w_boundary = w_slot_end && (r_digit_idx == 3'd7);
  assign w_copy     = w_boundary && (commit_pending || commit);

  // With no guard interval the comparison would be constant-false.
  generate
    if (GAP == 0) begin : g_no_gap
      assign w_gap_phase = 1'b0;
    end else begin : g_gap
      assign w_gap_phase = (r_div_cnt < CNT_W'(GAP));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt   <= '0;
      r_digit_idx <= 3'd0;
    end else if (w_slot_end) begin
      r_div_cnt   <= '0;
      r_digit_idx <= r_digit_idx + 3'd1;
    end else begin
      r_div_cnt   <= r_div_cnt + CNT_W'(1);
    end
  end

  // A write has priority over a same-cycle scroll.
  always_comb begin
    w_shadow_nxt = r_shadow;
    if (wr_en) begin
      w_shadow_nxt[wr_addr] = wr_char;
    end else if (shift_en) begin
      for (int i = 7; i > 0; i--) begin
        w_shadow_nxt[i] = r_shadow[i-1];
      end
      w_shadow_nxt[0] = shift_char;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_shadow[i]  <= C_SPACE;
        r_display[i] <= C_SPACE;
      end
    end else begin
      r_shadow <= w_shadow_nxt;
      if (w_copy) begin
        r_display <= w_shadow_nxt;
      end
    end
  end

  // The display buffer only changes on the boundary, so char_out holds per slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_n          <= 8'hFF;
      char_out       <= C_SPACE;
      frame_tick     <= 1'b0;
      commit_pending <= 1'b0;
    end else begin
      dig_n          <= (blank || w_gap_phase) ? 8'hFF : ~(8'h01 << r_digit_idx);
      char_out       <= r_display[r_digit_idx];
      frame_tick     <= w_boundary;
      commit_pending <= w_boundary ? 1'b0 : (commit_pending || commit);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Self-checking bench for seg_scan_ctrl against a cycle-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int GAP      = 1;
  localparam int FRAME    = 8 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_char;
  logic       shift_en;
  logic [7:0] shift_char;
  logic       commit;
  logic       blank;
  logic [7:0] char_out;
  logic [7:0] dig_n;
  logic       frame_tick;
  logic       commit_pending;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: cycles since reset plus the two buffers and the pending flag.
  int         m_cyc;
  logic [7:0] m_shadow  [8];
  logic [7:0] m_display [8];
  logic       m_pend;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .GAP(GAP)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_char        (wr_char),
    .shift_en       (shift_en),
    .shift_char     (shift_char),
    .commit         (commit),
    .blank          (blank),
    .char_out       (char_out),
    .dig_n          (dig_n),
    .frame_tick     (frame_tick),
    .commit_pending (commit_pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc  = 0;
    m_pend = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_shadow[i]  = 8'h20;
      m_display[i] = 8'h20;
    end
  endtask

  // One clock: drive inputs, advance model across the edge, compare #1 later.
  task automatic step(input logic we, input logic [2:0] wa, input logic [7:0] wc,
                      input logic se, input logic [7:0] sc, input logic cm, input logic bl);
    int         slot_pos, digit;
    logic [7:0] e_dig, e_char;
    logic       e_tick, bnd;
    logic [7:0] tmp [8];
    wr_en = we; wr_addr = wa; wr_char = wc;
    shift_en = se; shift_char = sc; commit = cm; blank = bl;
    @(posedge clk);
    slot_pos = m_cyc % SCAN_DIV;
    digit    = (m_cyc / SCAN_DIV) % 8;
    bnd      = ((m_cyc % FRAME) == FRAME - 1);
    e_dig    = (bl || slot_pos < GAP) ? 8'hFF : ~(8'(1) << digit);
    e_char   = m_display[digit];
    e_tick   = bnd;
    tmp = m_shadow;
    if (we) tmp[wa] = wc;
    else if (se) begin
      for (int i = 7; i > 0; i--) tmp[i] = m_shadow[i-1];
      tmp[0] = sc;
    end
    m_shadow = tmp;
    if (bnd) begin
      if (m_pend || cm) m_display = tmp;
      m_pend = 1'b0;
    end else begin
      m_pend = m_pend || cm;
    end
    m_cyc++;
    #1;
    check("dig_n",          32'(dig_n),          32'(e_dig));
    check("char_out",       32'(char_out),       32'(e_char));
    check("frame_tick",     32'(frame_tick),     32'(e_tick));
    check("commit_pending", 32'(commit_pending), 32'(m_pend));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 3'd0, 8'h00, 0, 8'h00, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dig_n"},  32'(dig_n),          32'hFF);
    check({tag, "_char"},   32'(char_out),       32'h20);
    check({tag, "_tick"},   32'(frame_tick),     32'h0);
    check({tag, "_pend"},   32'(commit_pending), 32'h0);
  endtask

  initial begin
    bit reached;
    rst_n = 1'b0; wr_en = 0; wr_addr = 0; wr_char = 0;
    shift_en = 0; shift_char = 0; commit = 0; blank = 0;
    model_reset();
    #12;
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Idle scan: two full frames of spaces with periodic frame_tick.
    idle(2 * FRAME + 3);

    // Write "0".."7" then commit mid-frame.
    for (int i = 0; i < 8; i++) step(1, 3'(i), 8'h30 + 8'(i), 0, 8'h00, 0, 0);
    step(0, 3'd0, 8'h00, 0, 8'h00, 1, 0);
    step(0, 3'd0, 8'h00, 0, 8'h00, 1, 0);
    idle(2 * FRAME);

    // Write/shift collision: write wins.
    step(1, 3'd0, 8'h41, 1, 8'h42, 0, 0);
    step(0, 3'd0, 8'h00, 0, 8'h00, 1, 0);
    idle(2 * FRAME);

    // Scroll three characters in from the right.
    step(0, 3'd0, 8'h00, 1, 8'h46, 0, 0);
    step(0, 3'd0, 8'h00, 1, 8'h45, 0, 0);
    step(0, 3'd0, 8'h00, 1, 8'h44, 1, 0);
    idle(2 * FRAME);

    // Blank for 10 cycles mid-slot.
    idle(5);
    for (int i = 0; i < 10; i++) step(0, 3'd0, 8'h00, 0, 8'h00, 0, 1);
    idle(FRAME + 4);

    // Commit on the exact boundary cycle, after a write in that cycle.
    reached = 0;
    for (int i = 0; i < 2 * FRAME && !reached; i++) begin
      if ((m_cyc % FRAME) == FRAME - 1) reached = 1;
      else idle(1);
    end
    check("wait_boundary", 32'(reached), 32'h1);
    step(1, 3'd3, 8'h5A, 0, 8'h00, 1, 0);
    idle(FRAME + 2);

    // Asynchronous reset while digit 5 is showing.
    reached = 0;
    for (int i = 0; i < 2 * FRAME && !reached; i++) begin
      idle(1);
      if (((m_cyc - 1) / SCAN_DIV) % 8 == 5 && ((m_cyc - 1) % SCAN_DIV) >= GAP) reached = 1;
    end
    check("wait_digit5", 32'(reached), 32'h1);
    check("pre_rst_lit", 32'(dig_n), 32'hDF);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #3;
    check_reset_outputs("held_rst");
    rst_n = 1'b1;
    model_reset();
    idle(6);
    // Committing an untouched shadow must show spaces everywhere.
    step(0, 3'd0, 8'h00, 0, 8'h00, 1, 0);
    idle(2 * FRAME);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      logic we, se, cm, bl;
      we = ($urandom_range(0, 3) == 0);
      se = ($urandom_range(0, 9) == 0);
      cm = ($urandom_range(0, 19) == 0);
      bl = ($urandom_range(0, 9) == 0);
      step(we, 3'($urandom_range(0, 7)), 8'($urandom_range(32'h20, 32'h7E)),
           se, 8'($urandom_range(32'h20, 32'h7E)), cm, bl);
    end
    idle(2 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
